// File: rtl/instr_encode_loader_if.sv
// Request and instruction-memory write bus for instr_encode_loader.
// slave is the loader's view; master is the producer/memory environment's view.
interface instr_encode_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave (
    input  in_valid, op_sel, rs, rt, rd, shamt, imm, mem_ack,
    output in_ready, mem_req, mem_addr, mem_wdata
  );
  modport master (
    output in_valid, op_sel, rs, rt, rd, shamt, imm, mem_ack,
    input  in_ready, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes MIPS-style R/I instructions and writes them sequentially into instruction memory.
// Optional macro ENC_FIELD_CHECK_EN rejects requests with nonzero don't-care fields instead of masking them.
module instr_encode_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_encode_loader_if.slave   bus,
  output logic [15:0]            count,
  output logic                   err_illegal
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]  state;
  logic [31:0] enc;
  logic        illegal;
  logic [31:0] addr_q, wdata_q;

  // Combinational encoder for the request currently on the bus.
  always_comb begin
    logic [5:0] funct;
    logic [5:0] opc;
    logic       shift_op;
    funct    = 6'b000000;
    opc      = 6'b000000;
    shift_op = 1'b0;
    enc      = 32'h0;
    illegal  = 1'b0;
    case (bus.op_sel)
      4'd0: funct = 6'b100000;
      4'd1: funct = 6'b100010;
      4'd2: funct = 6'b100100;
      4'd3: funct = 6'b100101;
      4'd4: funct = 6'b100110;
      4'd5: begin funct = 6'b000000; shift_op = 1'b1; end
      4'd6: begin funct = 6'b000010; shift_op = 1'b1; end
      4'd7:  opc = 6'b001000;
      4'd8:  opc = 6'b001100;
      4'd9:  opc = 6'b001101;
      4'd10: opc = 6'b001110;
      4'd11: opc = 6'b001111;
      4'd12: opc = 6'b100011;
      4'd13: opc = 6'b101011;
      default: illegal = 1'b1;
    endcase
    if (bus.op_sel <= 4'd6) begin
      enc = {6'b000000, (shift_op ? 5'd0 : bus.rs), bus.rt, bus.rd,
             (shift_op ? bus.shamt : 5'd0), funct};
`ifdef ENC_FIELD_CHECK_EN
      if (shift_op && bus.rs != 5'd0)     illegal = 1'b1;
      if (!shift_op && bus.shamt != 5'd0) illegal = 1'b1;
`endif
    end else if (!illegal) begin
      enc = {opc, (bus.op_sel == 4'd11 ? 5'd0 : bus.rs), bus.rt, bus.imm};
`ifdef ENC_FIELD_CHECK_EN
      if (bus.op_sel == 4'd11 && bus.rs != 5'd0) illegal = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= BASE_ADDR;
      wdata_q     <= 32'h0;
      count       <= 16'h0;
      err_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          if (illegal) begin
            err_illegal <= 1'b1;
          end else begin
            wdata_q <= enc;
            state   <= WRITE;
          end
        end
        WRITE: if (bus.mem_ack) begin
          state  <= IDLE;
          addr_q <= addr_q + 32'd4;
          if (count != 16'hFFFF) count <= count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is gated by rst_n so nothing is accepted while reset is held.
  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.mem_req   = (state == WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: doc/instr_encode_loader.md
INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first instruction written after reset.
REQ-002 SHALL have port clk, input, 1, the sole clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, the producer offers one instruction request.
REQ-005 SHALL have port in_ready, output, 1, the block accepts a request this cycle.
REQ-006 SHALL have port op_sel, input, 4, the mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 ADDI, 8 ANDI, 9 ORI, 10 XORI, 11 LUI, 12 LW, 13 SW, 14-15 illegal.
REQ-007 SHALL have ports rs, rt, rd, shamt, each input, 5, the register and shift-amount fields.
REQ-008 SHALL have port imm, input, 16, the I-type immediate or offset.
REQ-009 SHALL have port mem_req, output, 1, a write request to instruction memory.
REQ-010 SHALL have port mem_ack, input, 1, memory accepts the write in this cycle.
REQ-011 SHALL have ports mem_addr and mem_wdata, each output, 32, the write address and the encoded instruction.
REQ-012 SHALL have port count, output, 16, the number of instructions written.
REQ-013 SHALL have port err_illegal, output, 1, sticky flag set when an illegal request is rejected.

Function
REQ-014 SHALL use a two-state FSM. In IDLE, in_ready=1. In WRITE, in_ready=0 and mem_req=1.
REQ-015 SHALL accept a request on the cycle where in_valid and in_ready are both 1. On that edge it SHALL register the encoded word and enter WRITE, so mem_req rises on the next cycle (latency 1).
REQ-016 SHALL encode R-type words as opcode[31:26]=000000, rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]. The funct values SHALL be ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLL 000000, SRL 000010.
REQ-017 SHALL force the rs field to 0 for SLL and SRL, and SHALL force the shamt field to 0 for ADD, SUB, AND, OR and XOR.
REQ-018 SHALL encode I-type words as opcode[31:26], rs[25:21], rt[20:16], imm[15:0]. The opcodes SHALL be ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LUI 001111, LW 100011, SW 101011.
REQ-019 SHALL force the rs field to 0 for LUI.
REQ-020 SHALL hold mem_req, mem_addr and mem_wdata stable in WRITE until the cycle in which mem_ack=1.
REQ-021 On the mem_ack edge, the block SHALL return to IDLE, advance mem_addr by 4 and increment count.
REQ-022 SHALL let mem_addr wrap modulo 2^32, and count SHALL saturate at 16'hFFFF.
REQ-023 SHALL ignore mem_ack while in IDLE.
REQ-024 On an accepted illegal op_sel, the block SHALL set err_illegal, remain in IDLE, issue no write, and leave mem_addr and count unchanged.
REQ-025 Back-to-back operation SHALL be possible: the earliest next accept is the cycle after the mem_ack edge, giving a throughput of 1 write per 2 cycles with zero memory wait.

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL go to state IDLE with mem_req=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, err_illegal=0, and in_ready=0 while rst_n=0.
REQ-027 Reset during WRITE SHALL abandon the pending write. mem_req SHALL be 0 the cycle after the reset edge, and the aborted write SHALL not be counted.

Configuration
REQ-028 When macro ENC_FIELD_CHECK_EN is defined, the following requests SHALL additionally be treated as illegal per REQ-024: R-type non-shift with shamt≠0, SLL/SRL with rs≠0, and LUI with rs≠0.
REQ-029 When ENC_FIELD_CHECK_EN is undefined, those fields SHALL be silently forced to 0 per REQ-017 and REQ-019, and no error SHALL be raised.

Verification
REQ-030 Accept ADD rs=1 rt=2 rd=3 after reset with mem_ack tied high -> mem_wdata=32'h0022_1820, mem_addr=0, then count=1 and mem_addr=4.
REQ-031 Accept ADDI rs=1 rt=2 imm=16'hFFFF, then LW rs=29 rt=8 imm=4 -> 32'h2022_FFFF at address 0, then 32'h8FA8_0004 at address 4.
REQ-032 Accept SW with mem_ack held low for 5 cycles -> mem_req, mem_addr and mem_wdata stay constant and in_ready stays 0 for 5 cycles; count increments only on the ack edge.
REQ-033 Accept op_sel=14 -> err_illegal=1 (sticky), no mem_req, and mem_addr and count unchanged; a following valid op still writes correctly.
REQ-034 Assert rst_n=0 for 1 cycle mid-WRITE -> mem_req=0 and mem_addr=BASE_ADDR next cycle, count=0; a later ack causes no change.
REQ-035 Accept SLL rs=7 rt=4 rd=5 shamt=2 -> with ENC_FIELD_CHECK_EN, err_illegal=1 and no write; without it, mem_wdata=32'h0004_2880.
